// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// Holds the controller state encoding, operation select and iteration count.
package multdiv_ctrl_pkg;

  localparam int unsigned N_ITER = 32;
  localparam int unsigned CNT_W  = $clog2(N_ITER);

  typedef enum logic [2:0] {
    StIdle,
    StNegB,
    StNegA,
    StIter,
    StFix,
    StDone
  } state_e;

  typedef enum logic {
    OpMul,
    OpDiv
  } op_e;

endpackage

// File: rtl/cla.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups.
// No carry-in; the carry-out and signed overflow are provided.
module cla (
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_s,
  output logic        o_c,
  output logic        o_ovf
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = i_x & i_y;
  assign w_p = i_x ^ i_y;

  always_comb begin
    w_c = '0;
    for (int gi = 0; gi < 8; gi++) begin
      w_c[4*gi+1] = w_g[4*gi] | (w_p[4*gi] & w_c[4*gi]);
      w_c[4*gi+2] = w_g[4*gi+1] | (w_p[4*gi+1] & w_g[4*gi])
                  | (w_p[4*gi+1] & w_p[4*gi] & w_c[4*gi]);
      w_c[4*gi+3] = w_g[4*gi+2] | (w_p[4*gi+2] & w_g[4*gi+1])
                  | (w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi])
                  | (w_p[4*gi+2] & w_p[4*gi+1] & w_p[4*gi] & w_c[4*gi]);
      // Group carry-out feeds the next group directly from the group carry-in.
      w_c[4*gi+4] = w_g[4*gi+3] | (w_p[4*gi+3] & w_g[4*gi+2])
                  | (w_p[4*gi+3] & w_p[4*gi+2] & w_g[4*gi+1])
                  | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi])
                  | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_p[4*gi] & w_c[4*gi]);
    end
  end

  assign o_s   = w_p ^ w_c[31:0];
  assign o_c   = w_c[32];
  assign o_ovf = w_c[31] ^ w_c[32];

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply/divide controller sharing one CLA for
// operand negation, 32 shift-add/shift-subtract steps and sign correction.
module multdiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  import multdiv_ctrl_pkg::*;

  state_e             r_state;
  state_e             w_state_d;
  op_e                r_op;
  logic               r_sa;
  logic               r_sb;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_absb;
  logic [31:0]        r_mb;
  logic [31:0]        r_q;
  logic [31:0]        r_rem;
  logic [31:0]        r_result;
  logic               r_exc;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_start;
  logic               w_div0;
  logic               w_last;
  logic               w_neg;
  logic [31:0]        w_rsh;
  logic [31:0]        w_x;
  logic [31:0]        w_y;
  logic [31:0]        w_s;
  logic               w_c;
  logic               w_unused_ovf;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_div0  = ctrl_DIV & ~ctrl_MULT & (data_operandB == 32'd0);
  assign w_last  = (r_cnt == CNT_W'(N_ITER - 1));
  assign w_neg   = r_sa ^ r_sb;
  assign w_rsh   = {r_rem[30:0], r_q[31]};

  // Shared adder input mux; negations use ~x + 1 since the adder has no carry-in.
  always_comb begin
    w_x = '0;
    w_y = '0;
    unique case (r_state)
      StNegB: begin
        w_x = ~r_b;
        w_y = 32'd1;
      end
      StNegA: begin
        w_x = ~r_a;
        w_y = 32'd1;
      end
      StIter: begin
        if (r_op == OpMul) begin
          w_x = r_rem;
          w_y = r_absb;
        end else begin
          w_x = w_rsh;
          w_y = r_mb;
        end
      end
      StFix: begin
        w_x = ~r_q;
        w_y = 32'd1;
      end
      default: ;
    endcase
  end

  cla u_cla (
    .i_x   (w_x),
    .i_y   (w_y),
    .o_s   (w_s),
    .o_c   (w_c),
    .o_ovf (w_unused_ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (w_start) begin
      w_state_d = w_div0 ? StDone : StNegB;
    end else begin
      unique case (r_state)
        StIdle:  w_state_d = StIdle;
        StNegB:  w_state_d = StNegA;
        StNegA:  w_state_d = StIter;
        StIter:  w_state_d = w_last ? StFix : StIter;
        StFix:   w_state_d = StDone;
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    data_resultRDY = (r_state == StDone);
    busy           = (r_state != StIdle);
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op     <= OpMul;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_absb   <= '0;
      r_mb     <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_op  <= ctrl_MULT ? OpMul : OpDiv;
      r_a   <= data_operandA;
      r_b   <= data_operandB;
      r_sa  <= data_operandA[31];
      r_sb  <= data_operandB[31];
      r_cnt <= '0;
      if (w_div0) begin
        r_result <= '0;
        r_exc    <= 1'b1;
      end
    end else begin
      unique case (r_state)
        StNegB: begin
          r_absb <= r_sb ? w_s : r_b;
          r_mb   <= r_sb ? r_b : w_s;
        end
        StNegA: begin
          r_q   <= r_sa ? w_s : r_a;
          r_rem <= '0;
          r_cnt <= '0;
        end
        StIter: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == OpMul) begin
            if (r_q[0]) begin
              r_rem <= {w_c, w_s[31:1]};
              r_q   <= {w_s[0], r_q[31:1]};
            end else begin
              r_rem <= {1'b0, r_rem[31:1]};
              r_q   <= {r_rem[0], r_q[31:1]};
            end
          end else begin
            // Carry-out of R' + (-|B|) means R' >= |B|: keep the difference.
            r_rem <= w_c ? w_s : w_rsh;
            r_q   <= {r_q[30:0], w_c};
          end
        end
        StFix: begin
          r_result <= w_neg ? w_s : r_q;
          if (r_op == OpMul) begin
            r_exc <= (r_rem != 32'd0) |
                     (r_q[31] & ~(w_neg & (r_q == 32'h8000_0000)));
          end else begin
            r_exc <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed corner cases, abort/reset
// scenarios and random operands against a 64-bit arithmetic reference.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_ctrl u_dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact 64-bit signed arithmetic, truncating division.
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint la;
    longint lb;
    longint p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (is_mul) begin
      p = la * lb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      p = la / lb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = 32'($urandom_range(0, 65535)) - 32'd32768;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic do_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    model(is_mul, a, b, exp_r, exp_e);
    exp_lat = (!is_mul && b == 32'd0) ? 0 : 35;
    @(negedge clock);
    ctrl_MULT     = is_mul;
    ctrl_DIV      = !is_mul;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    // Operands must only matter on the start edge.
    data_operandA = $urandom;
    data_operandB = $urandom;
    check_eq({tag, "_busy_start"}, busy, 1);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_result"}, data_result, exp_r);
    check_eq({tag, "_exc"}, data_exception, exp_e);
    check_eq({tag, "_busy_rdy"}, busy, 1);
    @(negedge clock);
    check_eq({tag, "_rdy_pulse"}, data_resultRDY, 0);
    check_eq({tag, "_busy_end"}, busy, 0);
    repeat (2) @(negedge clock);
    check_eq({tag, "_hold"}, data_result, exp_r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_rdy;
    int          first;
    logic [31:0] got_r;
    logic [31:0] ra;
    logic [31:0] rb;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_result", data_result, 0);
    check_eq("rst_exc", data_exception, 0);
    check_eq("rst_rdy", data_resultRDY, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    do_op(1'b1, 32'd7, -32'sd6, "mul_7x-6");
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "mul_min_x_m1");
    do_op(1'b1, 32'h8000_0000, 32'd1, "mul_min_x_1");
    do_op(1'b1, 32'd65536, 32'd65536, "mul_2p16_sq");
    do_op(1'b0, -32'sd100, 32'd7, "div_m100_7");
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, "div_min_min");
    do_op(1'b0, 32'd5, 32'd0, "div_by_zero");
    do_op(1'b0, 32'd9, 32'd3, "div_9_3");

    // Abort: a MULT start ten cycles into a DIV replaces it.
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (9) @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    n_rdy = 0;
    first = -1;
    got_r = '0;
    for (int k = 0; k < 60; k++) begin
      if (data_resultRDY) begin
        n_rdy++;
        if (first < 0) begin
          first = k;
          got_r = data_result;
        end
      end
      @(negedge clock);
    end
    check_eq("abort_rdy_count", n_rdy, 1);
    check_eq("abort_latency", first, 35);
    check_eq("abort_result", got_r, 12);

    // Reset twenty cycles into a MUL abandons it and clears outputs.
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd7;
    data_operandB = -32'sd6;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("midrst_result", data_result, 0);
    check_eq("midrst_exc", data_exception, 0);
    check_eq("midrst_rdy", data_resultRDY, 0);
    check_eq("midrst_busy", busy, 0);
    n_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      if (data_resultRDY) n_rdy++;
      @(negedge clock);
    end
    check_eq("midrst_no_rdy", n_rdy, 0);

    for (int i = 0; i < 60; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      do_op(($urandom_range(0, 1) == 1), ra, rb, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
